game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//   Top-level game-flow FSM; direct upstream of the RGB render stage. Produces the four
//   one-hot screen flags (menu/playing/continue/final), lives, level and a countdown for
//   the number overlay. All screen changes are frame-aligned so a frame never mixes screens.
// PARAMETERS
//   LIVES_INIT   3   lives loaded on game start / continue
//   LEVELS       3   number of levels; clearing level LEVELS-1 ends the game (FINAL)
//   FPS          60  frame_tick_i pulses per second
//   CONT_SECS    9   continue-screen countdown start value, seconds
//   FINAL_SECS   5   final-screen dwell, seconds
// PORTS
//   clk_i          in   1   pixel clock
//   rst_ni         in   1   reset, synchronous, active-low
//   frame_tick_i   in   1   1-cycle pulse at start of vertical blanking
//   start_btn_i    in   1   start button level, already synchronised and debounced
//   player_hit_i   in   1   1-cycle pulse: player destroyed
//   level_clear_i  in   1   1-cycle pulse: all targets of current level destroyed
//   is_menu_o      out  1   screen flag; exactly one of the four flags is 1 at all times
//   is_playing_o   out  1   screen flag
//   is_continue_o  out  1   screen flag
//   is_final_o     out  1   screen flag
//   lives_o        out  2   remaining lives
//   level_o        out  2   current level, 0-based
//   countdown_o    out  4   whole seconds remaining (CONTINUE/FINAL), else 0
//   game_reset_o   out  1   1-cycle pulse: reload map/player/bullet positions
// BEHAVIOUR
//   Reset (rst_ni=0 at an edge): state MENU; is_menu_o=1, other flags 0; lives_o=0,
//     level_o=0, countdown_o=0, game_reset_o=0; pending flags, sub-counter and button history cleared.
//     Applies mid-game identically; no frame alignment on reset.
//   Event capture: rising edge of start_btn_i, player_hit_i, level_clear_i set sticky pending
//     flags start_p/hit_p/clr_p. On a frame_tick_i cycle an event arriving that same cycle counts
//     (flag OR input). All pending flags clear on every frame_tick_i, consumed or not.
//   FSM evaluates only on frame_tick_i=1; all outputs registered, change the cycle after the tick.
//   MENU:     start_p -> PLAYING, lives=LIVES_INIT, level=0, game_reset_o pulse.
//   PLAYING:  clr_p (priority over hit_p; hit discarded):
//               level==LEVELS-1 -> FINAL, countdown=FINAL_SECS, sub=FPS-1;
//               else level+1, game_reset_o pulse.
//             hit_p only: lives==1 -> lives=0, CONTINUE, countdown=CONT_SECS, sub=FPS-1;
//               else lives-1, game_reset_o pulse.
//             start_p ignored.
//   CONTINUE: start_p -> PLAYING, lives=LIVES_INIT, level kept, countdown=0, game_reset_o pulse.
//             else countdown tick (below); expiry -> MENU, countdown=0, level=0.
//   FINAL:    start_p -> MENU early; else countdown tick; expiry -> MENU, level=0.
//   Countdown tick (per evaluated frame): sub>0 -> sub-1; sub==0 && countdown>0 -> countdown-1,
//     sub=FPS-1; sub==0 && countdown==0 -> expiry. CONTINUE with CONT_SECS=9 lasts 10*FPS frames.
//   Widths: lives/level saturate-free by construction (never underflow: lives==1 path handled);
//     sub counter $clog2(FPS) bits.
//   game_reset_o: exactly one clk_i cycle, coincident with the state/lives/level update.
// STRUCTURE
//   game_pkg: typedef enum logic [1:0] {ST_MENU, ST_PLAYING, ST_CONTINUE, ST_FINAL} game_state_e;
//     localparams for LIVES_W=2, LEVEL_W=2, CNT_W=4 shared with number overlay and renderer.
//   Sub-module rise_detect (1-bit registered edge detector, same clk/reset) for start_btn_i.
//   One state register, one next-state always_comb, registered one-hot decode of outputs.
// TESTING
//   Reset then start_btn_i high mid-frame -> after next frame_tick_i: is_playing_o=1, lives_o=3,
//     level_o=0, game_reset_o high exactly one cycle; no change before the tick.
//   PLAYING, three player_hit_i in three frames -> lives 2,1 then is_continue_o=1, countdown_o=9;
//     with no start, 10*60 ticks later is_menu_o=1, countdown_o=0.
//   CONTINUE at countdown_o=4, press start -> next tick is_playing_o=1, lives_o=3, level kept.
//   player_hit_i and level_clear_i in same frame at level 1 -> level_o=2, lives unchanged;
//     level_clear_i at level 2 -> is_final_o=1, countdown_o=5; 6*60 ticks -> is_menu_o=1.
//   rst_ni low for one cycle while in FINAL -> next cycle is_menu_o=1, all counters 0; a
//     pending hit captured before reset has no effect after it.
//   Every cycle: assert $onehot({is_menu_o,is_playing_o,is_continue_o,is_final_o}).

Source files
------------

// File: rtl/game_state_ctrl_pkg.sv
// Shared types and widths for the game-flow controller, number overlay and renderer.
package game_state_ctrl_pkg;
    typedef enum logic [1:0] {ST_MENU, ST_PLAYING, ST_CONTINUE, ST_FINAL} game_state_e;

    localparam int LIVES_W = 2;
    localparam int LEVEL_W = 2;
    localparam int CNT_W   = 4;
endpackage

// File: rtl/game_state_ctrl_if.sv
// Bus between game-event sources (master) and the game-flow controller (slave).
interface game_state_ctrl_if;
    import game_state_ctrl_pkg::*;

    // Event inputs are single-cycle pulses (start_btn_i is a level) with no back-pressure;
    // every output is registered and updates the cycle after a frame_tick_i.
    logic                 frame_tick_i;
    logic                 start_btn_i;
    logic                 player_hit_i;
    logic                 level_clear_i;
    logic                 is_menu_o;
    logic                 is_playing_o;
    logic                 is_continue_o;
    logic                 is_final_o;
    logic [LIVES_W-1:0]   lives_o;
    logic [LEVEL_W-1:0]   level_o;
    logic [CNT_W-1:0]     countdown_o;
    logic                 game_reset_o;
    game_state_e          dbg_state;

    modport master (
        output frame_tick_i, start_btn_i, player_hit_i, level_clear_i,
        input  is_menu_o, is_playing_o, is_continue_o, is_final_o,
        input  lives_o, level_o, countdown_o, game_reset_o, dbg_state
    );

    modport slave (
        input  frame_tick_i, start_btn_i, player_hit_i, level_clear_i,
        output is_menu_o, is_playing_o, is_continue_o, is_final_o,
        output lives_o, level_o, countdown_o, game_reset_o, dbg_state
    );
endinterface

// File: rtl/game_state_ctrl_rise_detect.sv
// Rising-edge detector: registered history bit, combinational pulse on a 0->1 change.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) prev <= 1'b0;
        else         prev <= d;
    end

    assign rise = d & ~prev;
endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow FSM: menu/playing/continue/final screens, lives, level and countdown,
// all updated only on frame ticks so a frame never mixes screens.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int LIVES_INIT = 3,
    parameter int LEVELS     = 3,
    parameter int FPS        = 60,
    parameter int CONT_SECS  = 9,
    parameter int FINAL_SECS = 5
) (
    input logic               clk_i,
    input logic               rst_ni,
    game_state_ctrl_if.slave  bus
);
    localparam int SUB_W = $clog2(FPS);
    localparam logic [SUB_W-1:0]   SUB_MAX   = SUB_W'(FPS - 1);
    localparam logic [LIVES_W-1:0] LIVES_RLD = LIVES_W'(LIVES_INIT);
    localparam logic [LEVEL_W-1:0] LAST_LVL  = LEVEL_W'(LEVELS - 1);

    game_state_e        state, nxt_state;
    logic [LIVES_W-1:0] lives, nxt_lives;
    logic [LEVEL_W-1:0] level, nxt_level;
    logic [CNT_W-1:0]   countdown, nxt_countdown;
    logic [SUB_W-1:0]   sub, nxt_sub;
    logic               nxt_game_reset, game_reset;
    logic               start_p, hit_p, clr_p;
    logic               start_rise, start_e, hit_e, clr_e;
    logic               is_menu, is_playing, is_continue, is_final;

    rise_detect u_start_rise (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (bus.start_btn_i),
        .rise   (start_rise)
    );

    // An event landing on the tick cycle itself still counts for that frame.
    assign start_e = start_p | start_rise;
    assign hit_e   = hit_p   | bus.player_hit_i;
    assign clr_e   = clr_p   | bus.level_clear_i;

    always_comb begin
        nxt_state      = state;
        nxt_lives      = lives;
        nxt_level      = level;
        nxt_countdown  = countdown;
        nxt_sub        = sub;
        nxt_game_reset = 1'b0;
        if (bus.frame_tick_i) begin
            unique case (state)
                ST_MENU: if (start_e) begin
                    nxt_state      = ST_PLAYING;
                    nxt_lives      = LIVES_RLD;
                    nxt_level      = '0;
                    nxt_game_reset = 1'b1;
                end
                ST_PLAYING: if (clr_e) begin
                    if (level == LAST_LVL) begin
                        nxt_state     = ST_FINAL;
                        nxt_countdown = CNT_W'(FINAL_SECS);
                        nxt_sub       = SUB_MAX;
                    end else begin
                        nxt_level      = level + LEVEL_W'(1);
                        nxt_game_reset = 1'b1;
                    end
                end else if (hit_e) begin
                    if (lives == LIVES_W'(1)) begin
                        nxt_lives     = '0;
                        nxt_state     = ST_CONTINUE;
                        nxt_countdown = CNT_W'(CONT_SECS);
                        nxt_sub       = SUB_MAX;
                    end else begin
                        nxt_lives      = lives - LIVES_W'(1);
                        nxt_game_reset = 1'b1;
                    end
                end
                ST_CONTINUE, ST_FINAL: begin
                    if (start_e) begin
                        nxt_countdown = '0;
                        nxt_sub       = '0;
                        if (state == ST_CONTINUE) begin
                            nxt_state      = ST_PLAYING;
                            nxt_lives      = LIVES_RLD;
                            nxt_game_reset = 1'b1;
                        end else begin
                            nxt_state = ST_MENU;
                            nxt_level = '0;
                        end
                    end else if (sub != '0) begin
                        nxt_sub = sub - SUB_W'(1);
                    end else if (countdown != '0) begin
                        nxt_countdown = countdown - CNT_W'(1);
                        nxt_sub       = SUB_MAX;
                    end else begin
                        nxt_state = ST_MENU;
                        nxt_level = '0;
                    end
                end
                default: nxt_state = ST_MENU;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_MENU;
            lives       <= '0;
            level       <= '0;
            countdown   <= '0;
            sub         <= '0;
            game_reset  <= 1'b0;
            start_p     <= 1'b0;
            hit_p       <= 1'b0;
            clr_p       <= 1'b0;
            is_menu     <= 1'b1;
            is_playing  <= 1'b0;
            is_continue <= 1'b0;
            is_final    <= 1'b0;
        end else begin
            state       <= nxt_state;
            lives       <= nxt_lives;
            level       <= nxt_level;
            countdown   <= nxt_countdown;
            sub         <= nxt_sub;
            game_reset  <= nxt_game_reset;
            start_p     <= bus.frame_tick_i ? 1'b0 : start_e;
            hit_p       <= bus.frame_tick_i ? 1'b0 : hit_e;
            clr_p       <= bus.frame_tick_i ? 1'b0 : clr_e;
            is_menu     <= (nxt_state == ST_MENU);
            is_playing  <= (nxt_state == ST_PLAYING);
            is_continue <= (nxt_state == ST_CONTINUE);
            is_final    <= (nxt_state == ST_FINAL);
        end
    end

    assign bus.is_menu_o     = is_menu;
    assign bus.is_playing_o  = is_playing;
    assign bus.is_continue_o = is_continue;
    assign bus.is_final_o    = is_final;
    assign bus.lives_o       = lives;
    assign bus.level_o       = level;
    assign bus.countdown_o   = countdown;
    assign bus.game_reset_o  = game_reset;
    assign bus.dbg_state     = state;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: frame-level reference model feeds an expected queue.
module tb_game_state_ctrl;
    localparam int W          = 13;
    localparam int LIVES_INIT = 3;
    localparam int LEVELS     = 3;
    localparam int FPS        = 60;
    localparam int CONT_SECS  = 9;
    localparam int FINAL_SECS = 5;
    localparam int SCR_MENU = 0, SCR_PLAY = 1, SCR_CONT = 2, SCR_FINAL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    game_state_ctrl_if bus ();

    game_state_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: screen, lives, level and frames remaining on timed screens.
    int m_screen = SCR_MENU, m_lives = 0, m_level = 0, m_frames_left = 0;
    bit m_start = 0, m_hit = 0, m_clr = 0, m_btn_prev = 0, m_greset = 0;
    bit btn_level = 0;

    function automatic int m_countdown();
        if (m_screen == SCR_CONT || m_screen == SCR_FINAL) return (m_frames_left - 1) / FPS;
        return 0;
    endfunction

    function automatic void go_menu();
        m_screen = SCR_MENU;
        m_level = 0;
        m_frames_left = 0;
    endfunction

    function automatic void model_step(bit rst, bit tick, bit btn, bit hit, bit clr);
        bit s, h, c;
        m_greset = 0;
        if (!rst) begin
            m_screen = SCR_MENU; m_lives = 0; m_level = 0; m_frames_left = 0;
            m_start = 0; m_hit = 0; m_clr = 0; m_btn_prev = 0;
            return;
        end
        s = m_start | (btn & ~m_btn_prev);
        h = m_hit | hit;
        c = m_clr | clr;
        m_btn_prev = btn;
        if (!tick) begin
            m_start = s; m_hit = h; m_clr = c;
            return;
        end
        m_start = 0; m_hit = 0; m_clr = 0;
        case (m_screen)
            SCR_MENU: if (s) begin
                m_screen = SCR_PLAY; m_lives = LIVES_INIT; m_level = 0; m_greset = 1;
            end
            SCR_PLAY: if (c) begin
                if (m_level == LEVELS - 1) begin
                    m_screen = SCR_FINAL; m_frames_left = (FINAL_SECS + 1) * FPS;
                end else begin
                    m_level++; m_greset = 1;
                end
            end else if (h) begin
                if (m_lives == 1) begin
                    m_lives = 0; m_screen = SCR_CONT; m_frames_left = (CONT_SECS + 1) * FPS;
                end else begin
                    m_lives--; m_greset = 1;
                end
            end
            SCR_CONT: if (s) begin
                m_screen = SCR_PLAY; m_lives = LIVES_INIT; m_frames_left = 0; m_greset = 1;
            end else begin
                m_frames_left--;
                if (m_frames_left == 0) go_menu();
            end
            default: if (s) go_menu();
            else begin
                m_frames_left--;
                if (m_frames_left == 0) go_menu();
            end
        endcase
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [3:0] scr;
        scr = 4'b1000 >> m_screen;
        return {scr, 2'(m_lives), 2'(m_level), 4'(m_countdown()), m_greset};
    endfunction

    task automatic drive(input bit rst, input bit tick, input bit btn, input bit hit, input bit clr);
        @(negedge clk);
        rst_n = rst;
        bus.frame_tick_i = tick;
        bus.start_btn_i = btn;
        bus.player_hit_i = hit;
        bus.level_clear_i = clr;
        model_step(rst, tick, btn, hit, clr);
        exp_q.push_back(model_out());
    endtask

    // One frame of len cycles ending in a tick; events land at random cycles inside it.
    task automatic frame(input int len, input bit hit, input bit clr, input bit press);
        int hp, cp, pp;
        hp = $urandom_range(0, len - 1);
        cp = $urandom_range(0, len - 1);
        pp = $urandom_range(1, len - 1);
        btn_level = 0;
        for (int i = 0; i < len; i++) begin
            if (press && i == pp) btn_level = 1;
            drive(1, i == len - 1, btn_level, hit && i == hp, clr && i == cp);
        end
    endtask

    always @(posedge clk) begin
        logic [W-1:0] exp_v, act_v;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.is_menu_o, bus.is_playing_o, bus.is_continue_o, bus.is_final_o,
                     bus.lives_o, bus.level_o, bus.countdown_o, bus.game_reset_o};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d flags got %b exp %b lives got %0d exp %0d level got %0d exp %0d cd got %0d exp %0d greset got %b exp %b",
                         cyc, act_v[12:9], exp_v[12:9], act_v[8:7], exp_v[8:7], act_v[6:5], exp_v[6:5],
                         act_v[4:1], exp_v[4:1], act_v[0], exp_v[0]);
            end
            vectors++;
            if (!$onehot({bus.is_menu_o, bus.is_playing_o, bus.is_continue_o, bus.is_final_o})) begin
                miscompares++;
                $display("FAIL onehot cyc=%0d flags got %b required one-hot",
                         cyc, {bus.is_menu_o, bus.is_playing_o, bus.is_continue_o, bus.is_final_o});
            end
        end
    end

    initial begin
        bus.frame_tick_i = 0; bus.start_btn_i = 0; bus.player_hit_i = 0; bus.level_clear_i = 0;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        frame(5, 0, 0, 0);
        frame(6, 0, 0, 1);
        for (int i = 0; i < 3; i++) frame(4, 1, 0, 0);
        for (int i = 0; i < (CONT_SECS + 1) * FPS; i++) frame(4, 0, 0, 0);
        frame(3, 0, 0, 0);

        frame(5, 0, 0, 1);
        for (int i = 0; i < 3; i++) frame(4, 1, 0, 0);
        for (int k = 0; k < 400 && !(m_screen == SCR_CONT && m_countdown() == 4); k++) frame(4, 0, 0, 0);
        frame(4, 0, 0, 1);

        frame(4, 0, 1, 0);
        frame(5, 1, 1, 0);
        frame(4, 0, 1, 0);
        for (int i = 0; i < (FINAL_SECS + 1) * FPS; i++) frame(4, 0, 0, 0);
        frame(3, 0, 0, 0);

        frame(4, 0, 0, 1);
        for (int i = 0; i < 3; i++) frame(4, 0, 1, 0);
        for (int i = 0; i < 20; i++) frame(4, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        frame(4, 0, 0, 0);
        frame(4, 0, 0, 1);
        frame(4, 0, 0, 0);
        frame(4, 0, 1, 0);
        frame(4, 0, 0, 1);

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 99) == 0) drive(0, 0, $urandom_range(0, 1), 0, 0);
            frame($urandom_range(1, 6), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0);
        end

        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain leftover got %0d entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
